minimac2_mdio_slave: RTL and testbench
======================================

MINIMAC2_MDIO_SLAVE -- requirements
Module: minimac2_mdio_slave

Interface
REQ-001 Parameter phy_addr, default 5'd1: PHYAD this responder answers to.
REQ-002 Parameter phy_id1, default 16'h0022: value returned for register 2.
REQ-003 Parameter phy_id2, default 16'h1619: value returned for register 3.
REQ-004 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 sys_rst_n  input  1  synchronous, active-low reset.
REQ-006 mdc  input  1  management clock from station, asynchronous to sys_clk, at most sys_clk/8.
REQ-007 mdio_i  input  1  management data input, sampled from the pad.
REQ-008 mdio_o  output  1  management data driven value.
REQ-009 mdio_oe  output  1  pad output enable; 1 = responder drives mdio_o.
REQ-010 status_i  input  16  live value returned for register 1.
REQ-011 ctrl_o  output  16  current content of register 0.
REQ-012 wr_stb  output  1  one-cycle pulse on each accepted write to register 0.

Function
REQ-013 mdc and mdio_i SHALL each pass through a 2-flop synchronizer; rise/fall events SHALL be derived from the synchronized mdc history.
REQ-014 mdio_i SHALL be sampled on the sys_clk cycle a synchronized mdc rise is detected; mdio_o/mdio_oe SHALL change only on the cycle a synchronized mdc fall is detected.
REQ-015 FSM states: PRE, ST, OP, ADDR, TA, RD, WR, SKIP.
REQ-016 PRE: saturating 6-bit ones counter, increment on sampled 1, clear on sampled 0; leave PRE to ST on a sampled 0 when the preamble condition (Configuration) holds.
REQ-017 ST: next sampled bit must be 1 (completing 01), else return to PRE with counter cleared.
REQ-018 OP: two bits; 10 = read, 01 = write; 00/11 SHALL return to PRE.
REQ-019 ADDR: ten bits, PHYAD then REGAD, MSB first; on mismatch with phy_addr go to SKIP after the tenth bit.
REQ-020 Read: mdio_oe SHALL stay 0 through the first TA bit; on the mdc fall after the first TA sample, mdio_oe=1, mdio_o=0.
REQ-021 Read: the 16-bit read word SHALL be latched at that same fall; bits 15..0 SHALL be presented on the following 16 mdc falls, one per fall.
REQ-022 Read: on the mdc fall after the 16th data bit's rise, mdio_oe=0 and the FSM SHALL enter PRE with counter cleared.
REQ-023 Read map: reg0 = ctrl_o, reg1 = status_i (sampled at latch time), reg2 = phy_id1, reg3 = phy_id2, REGAD 4..31 = 16'h0000.
REQ-024 Write: two TA bits SHALL be sampled and ignored, then 16 data bits shifted MSB first; after the 16th, if REGAD=0, ctrl_o SHALL update the next sys_clk cycle and wr_stb SHALL pulse for that cycle; other REGAD writes SHALL be discarded with no wr_stb.
REQ-025 Write data with bit 15 = 1 SHALL load ctrl_o then, one cycle later, restore 16'h1000 (self-clearing soft reset); wr_stb pulses once.
REQ-026 SKIP: mdio_oe=0; count 18 further mdc rises (TA + data), then PRE with counter cleared.
REQ-027 mdio_oe SHALL never be 1 outside the TA2 and RD windows of a read addressed to phy_addr.
REQ-028 A sampled 0 during PRE with insufficient ones SHALL only clear the counter.

Reset
REQ-029 With sys_rst_n=0 at a sys_clk rise: FSM=PRE, counters 0, mdio_oe=0, mdio_o=1, ctrl_o=16'h1000, wr_stb=0, synchronizers=0.
REQ-030 Reset mid-read SHALL release mdio_oe in the same cycle; no partial write SHALL reach ctrl_o.

Configuration
REQ-031 Macro MINIMAC2_MDIO_PREAMBLE_EN defined: leaving PRE SHALL require the ones counter = 32 (saturated) when the 0 is sampled.
REQ-032 MINIMAC2_MDIO_PREAMBLE_EN undefined (preamble suppression): leaving PRE SHALL require only at least one 1 sampled immediately before the 0.

Verification
REQ-033 32 ones, read PHYAD=1 REGAD=2 -> mdio_oe high from TA2, serial 0 then 16'h0022 MSB first, oe low after bit 0.
REQ-034 Write PHYAD=1 REGAD=0 data 16'h0140 -> ctrl_o=16'h0140, exactly one wr_stb pulse; subsequent read of reg0 returns 16'h0140.
REQ-035 Read PHYAD=5 -> mdio_oe stays 0 for whole frame; next frame to PHYAD=1 answered normally.
REQ-036 Write reg0 16'h8000 -> ctrl_o 16'h8000 for one cycle, then 16'h1000.
REQ-037 With MINIMAC2_MDIO_PREAMBLE_EN: 31 ones + read -> no response; undefined: 1 one + read of reg1 with status_i=16'h782D -> returns 16'h782D.
REQ-038 Assert sys_rst_n=0 during read data bit 7 -> mdio_oe=0 next cycle, ctrl_o=16'h1000, FSM in PRE.

Source files
------------

// File: rtl/minimac2_mdio_slave.sv
// MDIO management responder (clause-22 framing) clocked entirely by sys_clk.
// mdc/mdio_i are oversampled through 2-flop synchronizers and edge-detected.
// Optional build macro: MINIMAC2_MDIO_PREAMBLE_EN
//   defined   -> a full 32-bit preamble of ones is required before a frame
//   undefined -> preamble suppression: a single 1 before the start 0 suffices
module minimac2_mdio_slave #(
  parameter logic [4:0]  phy_addr = 5'd1,
  parameter logic [15:0] phy_id1  = 16'h0022,
  parameter logic [15:0] phy_id2  = 16'h1619
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic [15:0] status_i,
  output logic [15:0] ctrl_o,
  output logic        wr_stb
);

  typedef enum logic [2:0] {PRE, ST, OP, ADDR, TA, RD, WR, SKIP} state_t;

  state_t      r_state, w_stateNext;
  logic [1:0]  r_mdcSync, r_mdioSync;
  logic        r_mdcPrev;
  logic [5:0]  r_ones, w_onesNext;
  logic [4:0]  r_bitCnt, w_bitCntNext;
  logic        r_isRead, w_isReadNext;
  logic [8:0]  r_addr, w_addrNext;
  logic [15:0] r_shift, w_shiftNext;
  logic        r_oe, w_oeNext;
  logic        r_out, w_outNext;
  logic [15:0] r_ctrl, w_ctrlNext;
  logic        r_wrStb, w_wrStbNext;

  logic        w_rise, w_fall, w_bit, w_preOk;
  logic [15:0] w_readWord, w_wrWord;

  // Bring mdc and mdio_i into the sys_clk domain and keep one cycle of mdc history
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_mdcSync  <= 2'b00;
      r_mdioSync <= 2'b00;
      r_mdcPrev  <= 1'b0;
    end else begin
      r_mdcSync  <= {r_mdcSync[0], mdc};
      r_mdioSync <= {r_mdioSync[0], mdio_i};
      r_mdcPrev  <= r_mdcSync[1];
    end
  end

  assign w_rise   = r_mdcSync[1] & ~r_mdcPrev;
  assign w_fall   = ~r_mdcSync[1] & r_mdcPrev;
  assign w_bit    = r_mdioSync[1];
  assign w_wrWord = {r_shift[14:0], w_bit};

`ifdef MINIMAC2_MDIO_PREAMBLE_EN
  assign w_preOk = (r_ones == 6'd32);
`else
  assign w_preOk = (r_ones != 6'd0);
`endif

  // Register map seen by reads; REGAD sits in the low five bits of the address shifter
  always_comb begin
    w_readWord = 16'h0000;
    case (r_addr[4:0])
      5'd0:    w_readWord = r_ctrl;
      5'd1:    w_readWord = status_i;
      5'd2:    w_readWord = phy_id1;
      5'd3:    w_readWord = phy_id2;
      default: w_readWord = 16'h0000;
    endcase
  end

  // Frame decoder: advances on synchronized mdc rises, drives the pad only on falls
  always_comb begin
    w_stateNext  = r_state;
    w_onesNext   = r_ones;
    w_bitCntNext = r_bitCnt;
    w_isReadNext = r_isRead;
    w_addrNext   = r_addr;
    w_shiftNext  = r_shift;
    w_oeNext     = r_oe;
    w_outNext    = r_out;
    w_ctrlNext   = r_ctrl;
    w_wrStbNext  = 1'b0;

    // A soft-reset bit written into control clears itself on the following cycle
    if (r_ctrl[15]) w_ctrlNext = 16'h1000;

    case (r_state)
      PRE: begin
        if (w_rise) begin
          if (w_bit) begin
            if (r_ones != 6'd32) w_onesNext = r_ones + 6'd1;
          end else begin
            w_onesNext = 6'd0;
            if (w_preOk) w_stateNext = ST;
          end
        end
      end
      ST: begin
        if (w_rise) begin
          w_bitCntNext = 5'd0;
          w_onesNext   = 6'd0;
          w_stateNext  = w_bit ? OP : PRE;
        end
      end
      OP: begin
        if (w_rise) begin
          if (r_bitCnt == 5'd0) begin
            w_isReadNext = w_bit;
            w_bitCntNext = 5'd1;
          end else begin
            w_bitCntNext = 5'd0;
            w_stateNext  = (w_bit != r_isRead) ? ADDR : PRE;
          end
        end
      end
      ADDR: begin
        if (w_rise) begin
          w_addrNext = {r_addr[7:0], w_bit};
          if (r_bitCnt == 5'd9) begin
            w_bitCntNext = 5'd0;
            w_stateNext  = (r_addr[8:4] == phy_addr) ? TA : SKIP;
          end else begin
            w_bitCntNext = r_bitCnt + 5'd1;
          end
        end
      end
      TA: begin
        if (w_rise) begin
          if (r_bitCnt == 5'd0) begin
            w_bitCntNext = 5'd1;
          end else begin
            w_bitCntNext = 5'd0;
            w_stateNext  = r_isRead ? RD : WR;
          end
        end else if (w_fall && r_isRead && r_bitCnt == 5'd1) begin
          w_oeNext    = 1'b1;
          w_outNext   = 1'b0;
          w_shiftNext = w_readWord;
        end
      end
      RD: begin
        if (w_rise) begin
          if (r_bitCnt != 5'd16) w_bitCntNext = r_bitCnt + 5'd1;
        end else if (w_fall) begin
          if (r_bitCnt == 5'd16) begin
            w_oeNext     = 1'b0;
            w_outNext    = 1'b1;
            w_bitCntNext = 5'd0;
            w_onesNext   = 6'd0;
            w_stateNext  = PRE;
          end else begin
            w_outNext   = r_shift[15];
            w_shiftNext = {r_shift[14:0], 1'b0};
          end
        end
      end
      WR: begin
        if (w_rise) begin
          w_shiftNext = w_wrWord;
          if (r_bitCnt == 5'd15) begin
            w_bitCntNext = 5'd0;
            w_onesNext   = 6'd0;
            w_stateNext  = PRE;
            if (r_addr[4:0] == 5'd0) begin
              w_ctrlNext  = w_wrWord;
              w_wrStbNext = 1'b1;
            end
          end else begin
            w_bitCntNext = r_bitCnt + 5'd1;
          end
        end
      end
      SKIP: begin
        if (w_rise) begin
          if (r_bitCnt == 5'd17) begin
            w_bitCntNext = 5'd0;
            w_onesNext   = 6'd0;
            w_stateNext  = PRE;
          end else begin
            w_bitCntNext = r_bitCnt + 5'd1;
          end
        end
      end
      default: begin
        w_stateNext  = PRE;
        w_bitCntNext = 5'd0;
        w_onesNext   = 6'd0;
        w_oeNext     = 1'b0;
        w_outNext    = 1'b1;
      end
    endcase
  end

  // State register for the decoder, the pad driver and the control register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state  <= PRE;
      r_ones   <= 6'd0;
      r_bitCnt <= 5'd0;
      r_isRead <= 1'b0;
      r_addr   <= 9'd0;
      r_shift  <= 16'h0000;
      r_oe     <= 1'b0;
      r_out    <= 1'b1;
      r_ctrl   <= 16'h1000;
      r_wrStb  <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_ones   <= w_onesNext;
      r_bitCnt <= w_bitCntNext;
      r_isRead <= w_isReadNext;
      r_addr   <= w_addrNext;
      r_shift  <= w_shiftNext;
      r_oe     <= w_oeNext;
      r_out    <= w_outNext;
      r_ctrl   <= w_ctrlNext;
      r_wrStb  <= w_wrStbNext;
    end
  end

  assign mdio_o  = r_out;
  assign mdio_oe = r_oe;
  assign ctrl_o  = r_ctrl;
  assign wr_stb  = r_wrStb;

endmodule

// File: tb/tb_minimac2_mdio_slave.sv
// Directed bench for minimac2_mdio_slave: a table of read/write frames plus
// hand-written sequences for soft reset, preamble handling and reset mid-read.
module tb_minimac2_mdio_slave;

  localparam int HALF = 60;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic [15:0] status_i;
  logic [15:0] ctrl_o;
  logic        wr_stb;

  int testsRun    = 0;
  int testsFailed = 0;
  int stbCount    = 0;
  int cnt8000     = 0;

  logic capOe;
  logic capO;

  typedef struct {
    logic        isWrite;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] wdata;
    logic [15:0] status;
    logic        expResp;
    logic [15:0] expData;
    logic [15:0] expCtrl;
    int          expStb;
  } vec_t;

  vec_t vecs[12];

  minimac2_mdio_slave #(
    .phy_addr(5'd1),
    .phy_id1 (16'h0022),
    .phy_id2 (16'h1619)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .mdc      (mdc),
    .mdio_i   (mdio_i),
    .mdio_o   (mdio_o),
    .mdio_oe  (mdio_oe),
    .status_i (status_i),
    .ctrl_o   (ctrl_o),
    .wr_stb   (wr_stb)
  );

  // 100 MHz system clock
  always #5 sys_clk = ~sys_clk;

  // Count strobe cycles and cycles where the soft-reset value is visible
  always @(negedge sys_clk) begin
    if (wr_stb) stbCount <= stbCount + 1;
    if (ctrl_o == 16'h8000) cnt8000 <= cnt8000 + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // One mdc period: data set while mdc low, pad sampled just before the rise
  task automatic clockBit(input logic b);
    mdio_i = b;
    #HALF;
    capOe = mdio_oe;
    capO  = mdio_o;
    mdc = 1'b1;
    #HALF;
    mdc = 1'b0;
  endtask

  task automatic sendHeader(input int nOnes, input logic isRead, input logic [4:0] phy, input logic [4:0] regad);
    for (int i = 0; i < nOnes; i++) clockBit(1'b1);
    clockBit(1'b0);
    clockBit(1'b1);
    clockBit(isRead);
    clockBit(~isRead);
    for (int i = 4; i >= 0; i--) clockBit(phy[i]);
    for (int i = 4; i >= 0; i--) clockBit(regad[i]);
  endtask

  task automatic doRead(input int nOnes, input logic [4:0] phy, input logic [4:0] regad,
                        output logic [17:0] oeVec, output logic [15:0] data,
                        output logic oTa2, output logic oeAfter);
    sendHeader(nOnes, 1'b1, phy, regad);
    clockBit(1'b1);
    oeVec[17] = capOe;
    clockBit(1'b1);
    oeVec[16] = capOe;
    oTa2      = capO;
    for (int i = 15; i >= 0; i--) begin
      clockBit(1'b1);
      oeVec[i] = capOe;
      data[i]  = capO;
    end
    clockBit(1'b1);
    oeAfter = capOe;
  endtask

  task automatic doWrite(input int nOnes, input logic [4:0] phy, input logic [4:0] regad, input logic [15:0] data);
    sendHeader(nOnes, 1'b0, phy, regad);
    clockBit(1'b1);
    clockBit(1'b0);
    for (int i = 15; i >= 0; i--) clockBit(data[i]);
    clockBit(1'b1);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [17:0] oeVec;
    logic [15:0] data;
    logic        oTa2;
    logic        oeAfter;
    int          stbBefore;
    status_i = v.status;
    if (v.isWrite) begin
      stbBefore = stbCount;
      doWrite(32, v.phy, v.regad, v.wdata);
      checkOutput($sformatf("v%0d_wr_stb_count", idx), stbCount - stbBefore, v.expStb);
      checkOutput($sformatf("v%0d_ctrl_o", idx), {16'h0, ctrl_o}, {16'h0, v.expCtrl});
    end else begin
      doRead(32, v.phy, v.regad, oeVec, data, oTa2, oeAfter);
      checkOutput($sformatf("v%0d_oe_window", idx), {14'h0, oeVec}, v.expResp ? 32'h0001FFFF : 32'h0);
      checkOutput($sformatf("v%0d_oe_after", idx), {31'h0, oeAfter}, 32'h0);
      if (v.expResp) begin
        checkOutput($sformatf("v%0d_ta2_o", idx), {31'h0, oTa2}, 32'h0);
        checkOutput($sformatf("v%0d_read_data", idx), {16'h0, data}, {16'h0, v.expData});
      end
    end
  endtask

  initial begin
    logic [17:0] oeVec;
    logic [15:0] data;
    logic        oTa2;
    logic        oeAfter;
    int          stbBefore;
    int          c8000Before;

    //            wr    phy    reg    wdata     status    resp  expData   expCtrl   stb
    vecs[0]  = '{1'b0, 5'd1, 5'd2, 16'h0000, 16'h0000, 1'b1, 16'h0022, 16'h1000, 0};
    vecs[1]  = '{1'b0, 5'd1, 5'd3, 16'h0000, 16'h0000, 1'b1, 16'h1619, 16'h1000, 0};
    vecs[2]  = '{1'b0, 5'd1, 5'd1, 16'h0000, 16'h782D, 1'b1, 16'h782D, 16'h1000, 0};
    vecs[3]  = '{1'b0, 5'd1, 5'd0, 16'h0000, 16'h0000, 1'b1, 16'h1000, 16'h1000, 0};
    vecs[4]  = '{1'b1, 5'd1, 5'd0, 16'h0140, 16'h0000, 1'b0, 16'h0000, 16'h0140, 1};
    vecs[5]  = '{1'b0, 5'd1, 5'd0, 16'h0000, 16'h0000, 1'b1, 16'h0140, 16'h0140, 0};
    vecs[6]  = '{1'b1, 5'd1, 5'd4, 16'hABCD, 16'h0000, 1'b0, 16'h0000, 16'h0140, 0};
    vecs[7]  = '{1'b0, 5'd1, 5'd7, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0140, 0};
    vecs[8]  = '{1'b0, 5'd5, 5'd2, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0140, 0};
    vecs[9]  = '{1'b0, 5'd1, 5'd2, 16'h0000, 16'h0000, 1'b1, 16'h0022, 16'h0140, 0};
    vecs[10] = '{1'b1, 5'd5, 5'd0, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 16'h0140, 0};
    vecs[11] = '{1'b0, 5'd1, 5'd1, 16'h0000, 16'hA5A5, 1'b1, 16'hA5A5, 16'h0140, 0};

    mdc       = 1'b0;
    mdio_i    = 1'b1;
    status_i  = 16'h0000;
    sys_rst_n = 1'b0;
    repeat (4) @(negedge sys_clk);
    checkOutput("reset_mdio_oe", {31'h0, mdio_oe}, 32'h0);
    checkOutput("reset_mdio_o", {31'h0, mdio_o}, 32'h1);
    checkOutput("reset_ctrl_o", {16'h0, ctrl_o}, 32'h1000);
    checkOutput("reset_wr_stb", {31'h0, wr_stb}, 32'h0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

    // Self-clearing soft reset: 0x8000 visible for exactly one cycle
    stbBefore   = stbCount;
    c8000Before = cnt8000;
    doWrite(32, 5'd1, 5'd0, 16'h8000);
    repeat (4) @(negedge sys_clk);
    checkOutput("softrst_8000_cycles", cnt8000 - c8000Before, 32'd1);
    checkOutput("softrst_ctrl_o", {16'h0, ctrl_o}, 32'h1000);
    checkOutput("softrst_wr_stb_count", stbCount - stbBefore, 32'd1);

    // Preamble handling; two zeros first return the decoder to an empty preamble count
    clockBit(1'b0);
    clockBit(1'b0);
`ifdef MINIMAC2_MDIO_PREAMBLE_EN
    doRead(31, 5'd1, 5'd2, oeVec, data, oTa2, oeAfter);
    checkOutput("short_preamble_oe", {14'h0, oeVec}, 32'h0);
    checkOutput("short_preamble_oe_after", {31'h0, oeAfter}, 32'h0);
`else
    status_i = 16'h782D;
    doRead(1, 5'd1, 5'd1, oeVec, data, oTa2, oeAfter);
    checkOutput("suppressed_preamble_oe", {14'h0, oeVec}, 32'h0001FFFF);
    checkOutput("suppressed_preamble_data", {16'h0, data}, 32'h782D);
`endif

    // Reset asserted while read data bit 7 is on the pad
    doWrite(32, 5'd1, 5'd0, 16'h0140);
    checkOutput("pre_reset_ctrl_o", {16'h0, ctrl_o}, 32'h0140);
    sendHeader(32, 1'b1, 5'd1, 5'd2);
    clockBit(1'b1);
    clockBit(1'b1);
    for (int i = 15; i >= 8; i--) clockBit(1'b1);
    repeat (6) @(negedge sys_clk);
    checkOutput("midread_oe_before_reset", {31'h0, mdio_oe}, 32'h1);
    checkOutput("midread_bit7_value", {31'h0, mdio_o}, 32'h0);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    checkOutput("midread_oe_after_reset", {31'h0, mdio_oe}, 32'h0);
    checkOutput("midread_ctrl_after_reset", {16'h0, ctrl_o}, 32'h1000);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Decoder must be back in preamble: a fresh read is answered normally
    doRead(32, 5'd1, 5'd2, oeVec, data, oTa2, oeAfter);
    checkOutput("post_reset_oe", {14'h0, oeVec}, 32'h0001FFFF);
    checkOutput("post_reset_data", {16'h0, data}, 32'h0022);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
